// File: rtl/flit_buffer_fifo.sv
// flit_buffer_fifo
//   Router input-port flit buffer. It holds up to DEPTH flits between an
//   upstream and a downstream valid/ready channel. The read side is
//   first-word fall-through. The buffer also reports its occupancy, raises
//   an almost-full flag for upstream flow control, and supports a
//   synchronous flush.
//
// Parameters
//   WIDTH      flit width in bits
//   DEPTH      number of flit slots (power of two, >= 2)
//   AF_THRESH  almost_full asserts when count >= AF_THRESH (1..DEPTH)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   flush        synchronous clear of all stored flits
//   in_data      upstream flit
//   in_valid     upstream flit present
//   in_ready     buffer can accept a flit this cycle
//   out_data     head flit (don't-care while out_valid is low)
//   out_valid    head flit present
//   out_ready    downstream takes the head flit this cycle
//   count        number of stored flits
//   almost_full  count >= AF_THRESH
module flit_buffer_fifo #(
    parameter int WIDTH     = 11,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             rdy_en;
    logic             push;
    logic             pop;

    // rdy_en keeps in_ready low while reset is asserted. It releases the
    // upstream side on the first clock edge after rst_n deasserts.
    assign in_ready    = rdy_en && (count < CW'(DEPTH));
    assign out_valid   = (count != '0);
    assign out_data    = mem[rd_ptr];
    assign almost_full = (count >= CW'(AF_THRESH));

    // Flush wins over both handshakes, so nothing is transferred on that edge.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                // Pointers are log2(DEPTH) bits wide, so they wrap naturally.
                // Full and empty are told apart by count alone.
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage is never reset. Its contents only matter while out_valid is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: doc/flit_buffer_fifo.md
Name: flit_buffer_fifo

Overview:
- Parametrised, clocked successor to the single-slot flit buffer in the router datapath.
- Holds up to DEPTH flits of WIDTH bits between an upstream channel and a downstream channel, each with a valid/ready handshake.
- Adds occupancy reporting, an almost-full flag for upstream flow control, and a synchronous flush.
- Sits at each router input port, ahead of the route-compute and arbitration logic.

Parameters:
- WIDTH, 11, flit width in bits (router flit format).
- DEPTH, 4, number of flit slots; power of two, >= 2.
- AF_THRESH, 3, almost_full asserts when count >= AF_THRESH; 1 <= AF_THRESH <= DEPTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all stored flits.
- in_data  input  WIDTH  upstream flit.
- in_valid  input  1  upstream flit present.
- in_ready  output  1  buffer can accept a flit this cycle.
- out_data  output  WIDTH  head flit.
- out_valid  output  1  head flit present.
- out_ready  input  1  downstream accepts the head flit this cycle.
- count  output  $clog2(DEPTH+1)  number of stored flits.
- almost_full  output  1  count >= AF_THRESH.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_ptr, wr_ptr and count go to 0; out_valid=0, almost_full=0.
  - in_ready is held 0 while rst_n is low.
  - out_data is don't-care while out_valid=0; storage contents are not cleared.
- Release: in_ready=1 from the first rising edge after rst_n deasserts.
- Push: occurs on an edge where in_valid && in_ready && !flush.
  - mem[wr_ptr] <= in_data; wr_ptr increments modulo DEPTH.
- Pop: occurs on an edge where out_valid && out_ready && !flush.
  - rd_ptr increments modulo DEPTH.
- Handshake rules:
  - in_ready = (count < DEPTH), combinational from registered count only.
  - A pop in the same cycle does not open a slot when full; there is no combinational ready pass-through.
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr] (first-word fall-through).
  - Once out_valid is high, out_data stays stable until popped.
- Latency: a flit pushed at edge N is visible on out_data/out_valid after edge N (one cycle). There is no same-cycle in-to-out bypass.
- Count:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
  - neither: unchanged.
- Full (count == DEPTH): in_ready=0 and in_valid is ignored. A pop that cycle brings count to DEPTH-1, so in_ready returns to 1 the next cycle.
- Empty (count == 0): out_valid=0 and out_ready is ignored. A simultaneous push takes count to 1.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally; the full/empty distinction comes from count, never from pointer equality.
- Flush:
  - On an edge with flush=1: rd_ptr=wr_ptr=0, count=0.
  - Any push or pop presented that cycle is discarded: no data is written and no flit is counted as transferred.
  - out_valid=0 the cycle after.
- Flags: almost_full = (count >= AF_THRESH), registered consistently with count (derived from the count register, not the next-state value).
- Reset mid-operation: all flits are lost immediately and outputs take their reset values asynchronously. No partial transfer is recorded.
- Ordering: strict FIFO; flits leave in arrival order with no duplication or loss.

Test Plan:
- Single flit: push 11'b01010100101 with out_ready=1 -> out_valid rises the cycle after the push, out_data=11'b01010100101, popped on the next edge, count returns 0.
- Fill to full: push 4 flits 0x0CE, 0x7CD, 0x788, 0x2A5 with out_ready=0 -> count steps 1..4, almost_full high from count=3, in_ready=0 at count=4; a 5th in_valid is not accepted.
- Drain: from full, hold out_ready=1 for 4 cycles -> out_data sequence 0x0CE, 0x7CD, 0x788, 0x2A5, then out_valid=0; in_ready rises the cycle after the first pop.
- Streaming with wrap-around: in_valid=out_ready=1 for 10 cycles with incrementing data 0x001..0x00A -> count stays 1 after fill, outputs in order, both pointers wrap twice, no loss.
- Flush: with 3 flits stored, assert flush together with in_valid=1 (0x3FF) and out_ready=1 -> next cycle count=0, out_valid=0, and 0x3FF never appears on out_data.
- Async reset: with 2 flits stored, pull rst_n low mid-cycle -> out_valid, count, almost_full and in_ready drop to 0 before the next edge; after release the buffer accepts and returns 0x155 correctly.
